// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one unified instruction/data memory port between
// the fetch unit (r0) and the load/store unit (r1); one transaction in flight.
module imem_dmem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_done,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_done,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_err,
  output logic                  mem_chip_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  logic                  mem_chip_sel_q, mem_chip_sel_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic [1:0]            gnt_s;
  logic                  win_s;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win_s = 1'b0;
    if (r0_req && r1_req) begin
      win_s = ~last_gnt_q;
    end else if (r1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_gnt_d     = last_gnt_q;
    id_d           = id_q;
    we_d           = we_q;
    mem_chip_sel_d = mem_chip_sel_q;
    mem_addr_d     = mem_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    mem_wr_en_d    = mem_wr_en_q;
    rdata_d        = rdata_q;
    done_d         = done_q;
    err_d          = err_q;
    gnt_s          = 2'b00;
    case (state_q)
      IDLE: begin
        done_d = 2'b00;
        err_d  = 2'b00;
        if (r0_req || r1_req) begin
          gnt_s[win_s]   = 1'b1;
          id_d           = win_s;
          last_gnt_d     = win_s;
          we_d           = win_s ? r1_we : r0_we;
          mem_addr_d     = win_s ? r1_addr : r0_addr;
          mem_wr_data_d  = win_s ? r1_wdata : r0_wdata;
          // Instruction space is read-only: the strobe is never raised there.
          mem_wr_en_d    = (win_s ? r1_we : r0_we) &
                           (win_s ? r1_addr[ADDR_WIDTH-1] : r0_addr[ADDR_WIDTH-1]);
          mem_chip_sel_d = 1'b1;
          state_d        = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        mem_wr_en_d = 1'b0;
        if (we_q) begin
          mem_chip_sel_d = 1'b0;
          rdata_d        = {DATA_WIDTH{1'b0}};
          done_d[id_q]   = 1'b1;
          err_d[id_q]    = ~mem_addr_q[ADDR_WIDTH-1];
          state_d        = RESP;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        mem_wr_en_d = 1'b0;
        if (cnt_q == 4'd0) begin
          mem_chip_sel_d = 1'b0;
          rdata_d        = mem_rd_data;
          done_d[id_q]   = 1'b1;
          err_d          = 2'b00;
          state_d        = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = WAIT;
        end
      end
      RESP: begin
        done_d  = 2'b00;
        err_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        mem_chip_sel_d = 1'b0;
        mem_wr_en_d    = 1'b0;
        done_d         = 2'b00;
        err_d          = 2'b00;
        state_d        = IDLE;
      end
    endcase
  end

  // State, command and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      last_gnt_q     <= 1'b1;
      id_q           <= 1'b0;
      we_q           <= 1'b0;
      mem_chip_sel_q <= 1'b0;
      mem_addr_q     <= {ADDR_WIDTH{1'b0}};
      mem_wr_data_q  <= {DATA_WIDTH{1'b0}};
      mem_wr_en_q    <= 1'b0;
      rdata_q        <= {DATA_WIDTH{1'b0}};
      done_q         <= 2'b00;
      err_q          <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_gnt_q     <= last_gnt_d;
      id_q           <= id_d;
      we_q           <= we_d;
      mem_chip_sel_q <= mem_chip_sel_d;
      mem_addr_q     <= mem_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      mem_wr_en_q    <= mem_wr_en_d;
      rdata_q        <= rdata_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign r0_gnt       = gnt_s[0];
  assign r1_gnt       = gnt_s[1];
  assign r0_done      = done_q[0];
  assign r1_done      = done_q[1];
  assign r0_err       = err_q[0];
  assign r1_err       = err_q[1];
  assign r0_rdata     = rdata_q;
  assign r1_rdata     = rdata_q;
  assign mem_chip_sel = mem_chip_sel_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_wr_en    = mem_wr_en_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: two instances (latency 1 and 3), each
// with a small memory model; completions are checked against a scoreboard.
module tb_imem_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] r0_req, r0_we, r1_req, r1_we, r0_gnt, r1_gnt, r0_done, r1_done;
  logic [1:0] r0_err, r1_err, mem_chip_sel, mem_wr_en;
  logic [1:0][31:0] r0_addr, r0_wdata, r1_addr, r1_wdata, r0_rdata, r1_rdata;
  logic [1:0][31:0] mem_addr, mem_wr_data, mem_rd_data;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [16];
    logic [31:0] pipe [LAT];
    logic [3:0]  idx;
    assign idx = {mem_addr[g][31], mem_addr[g][4:2]};
    assign mem_rd_data[g] = pipe[LAT-1];

    // Memory model: word index from {space bit, addr[4:2]}, LAT-cycle read pipe.
    always @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) mem[i] <= (i == 12) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
      end else begin
        if (mem_chip_sel[g] && mem_wr_en[g]) mem[idx] <= mem_wr_data[g];
        pipe[0] <= mem[idx];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
    end

    imem_dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req[g]), .r0_we(r0_we[g]), .r0_addr(r0_addr[g]), .r0_wdata(r0_wdata[g]),
      .r0_gnt(r0_gnt[g]), .r0_done(r0_done[g]), .r0_rdata(r0_rdata[g]), .r0_err(r0_err[g]),
      .r1_req(r1_req[g]), .r1_we(r1_we[g]), .r1_addr(r1_addr[g]), .r1_wdata(r1_wdata[g]),
      .r1_gnt(r1_gnt[g]), .r1_done(r1_done[g]), .r1_rdata(r1_rdata[g]), .r1_err(r1_err[g]),
      .mem_chip_sel(mem_chip_sel[g]), .mem_addr(mem_addr[g]), .mem_wr_data(mem_wr_data[g]),
      .mem_wr_en(mem_wr_en[g]), .mem_rd_data(mem_rd_data[g])
    );
  end

  typedef struct packed {
    logic        inst;
    logic        id;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [1:0]  gnt_flag, done_flag, gnt_who;
  int          gnt_cyc[2], done_cyc[2], wr_cnt[2], wr_cyc[2];
  logic        cs_hist[2][64];
  logic [31:0] addr_hist[2][64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, log events, score completions.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      cs_hist[i][cyc%64]   = mem_chip_sel[i];
      addr_hist[i][cyc%64] = mem_addr[i];
      if (mem_wr_en[i]) begin
        wr_cnt[i]++;
        wr_cyc[i] = cyc;
      end
      if (r0_gnt[i] || r1_gnt[i]) begin
        chk("gnt_onehot", {63'd0, r0_gnt[i] & r1_gnt[i]}, 64'd0);
        gnt_flag[i] = 1'b1;
        gnt_who[i]  = r1_gnt[i];
        gnt_cyc[i]  = cyc;
      end
      if (r0_done[i] || r1_done[i]) begin
        chk("done_onehot", {63'd0, r0_done[i] & r1_done[i]}, 64'd0);
        done_flag[i] = 1'b1;
        done_cyc[i]  = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_done", {63'd0, r0_done[i] | r1_done[i]}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_inst", 64'(i), {63'd0, e.inst});
          chk("done_id", {63'd0, r1_done[i]}, {63'd0, e.id});
          chk("done_err", {63'd0, r1_done[i] ? r1_err[i] : r0_err[i]}, {63'd0, e.err});
          if (e.chk_rd) chk("done_rdata", {32'd0, r1_done[i] ? r1_rdata[i] : r0_rdata[i]}, {32'd0, e.rdata});
        end
      end
    end
  endtask

  task automatic txn(input int inst, input bit id, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit chk_rd, input logic [31:0] exp_rd,
                     input bit exp_err, output int tg, output int td);
    bit got;
    @(posedge clk); #1;
    if (id) begin
      r1_req[inst] = 1'b1; r1_we[inst] = we; r1_addr[inst] = addr; r1_wdata[inst] = wdata;
    end else begin
      r0_req[inst] = 1'b1; r0_we[inst] = we; r0_addr[inst] = addr; r0_wdata[inst] = wdata;
    end
    sb.push_back(exp_t'{1'(inst), id, chk_rd, exp_rd, exp_err});
    gnt_flag[inst] = 1'b0;
    done_flag[inst] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      got = gnt_flag[inst];
    end
    chk("gnt_seen", {63'd0, got}, 64'd1);
    if (got) chk("gnt_who", {63'd0, gnt_who[inst]}, {63'd0, id});
    @(posedge clk); #1;
    // Scramble attributes after grant: the latched command must be used.
    r0_req[inst] = 1'b0; r1_req[inst] = 1'b0; r0_we[inst] = ~we; r1_we[inst] = ~we;
    r0_addr[inst] = ~addr; r1_addr[inst] = ~addr; r0_wdata[inst] = ~wdata; r1_wdata[inst] = ~wdata;
    for (int k = 0; k < 40 && !done_flag[inst]; k++) step();
    chk("done_seen", {63'd0, done_flag[inst]}, 64'd1);
    tg = gnt_cyc[inst];
    td = done_cyc[inst];
    r0_we[inst] = 1'b0; r1_we[inst] = 1'b0;
  endtask

  task automatic rr(input int inst, input int n, input int spacing);
    int tgs[8];
    int ng;
    @(posedge clk); #1;
    r0_req[inst] = 1'b1; r0_we[inst] = 1'b0; r0_addr[inst] = 32'h0000_0004;
    r1_req[inst] = 1'b1; r1_we[inst] = 1'b0; r1_addr[inst] = 32'h8000_0000;
    for (int j = 0; j < n; j++)
      sb.push_back(exp_t'{1'(inst), 1'(j % 2), 1'b1, (j % 2 == 1) ? 32'hA000_0008 : 32'hA000_0001, 1'b0});
    ng = 0;
    gnt_flag[inst] = 1'b0;
    for (int k = 0; k < 100 && ng < n; k++) begin
      step();
      if (gnt_flag[inst]) begin
        gnt_flag[inst] = 1'b0;
        chk("rr_order", {63'd0, gnt_who[inst]}, 64'(ng % 2));
        tgs[ng] = gnt_cyc[inst];
        if (ng > 0) chk("rr_spacing", 64'(tgs[ng] - tgs[ng-1]), 64'(spacing));
        ng++;
        if (ng == n) begin
          @(posedge clk); #1;
          r0_req[inst] = 1'b0; r1_req[inst] = 1'b0;
        end
      end
    end
    r0_req[inst] = 1'b0; r1_req[inst] = 1'b0;
    chk("rr_count", 64'(ng), 64'(n));
    for (int k = 0; k < 60 && sb.size() > 0; k++) step();
    chk("rr_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int tg, td, w0;
    bit got;
    r0_req = '0; r0_we = '0; r1_req = '0; r1_we = '0;
    r0_addr = '0; r0_wdata = '0; r1_addr = '0; r1_wdata = '0;
    gnt_flag = '0; done_flag = '0; gnt_who = '0;
    for (int i = 0; i < 2; i++) begin
      gnt_cyc[i] = 0; done_cyc[i] = 0; wr_cnt[i] = 0; wr_cyc[i] = 0;
    end

    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_chip_sel", {63'd0, mem_chip_sel[i]}, 64'd0);
      chk("rst_wr_en", {63'd0, mem_wr_en[i]}, 64'd0);
      chk("rst_addr", {32'd0, mem_addr[i]}, 64'd0);
      chk("rst_done", {62'd0, r0_done[i], r1_done[i]}, 64'd0);
      chk("rst_rdata", {32'd0, r0_rdata[i]}, 64'd0);
    end
    rst_n = 1'b1;

    rr(0, 4, 4);

    txn(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, tg, td);
    chk("rd_latency", 64'(td - tg), 64'd3);
    chk("rd_cs_t1", {63'd0, cs_hist[0][(tg+1)%64]}, 64'd1);
    chk("rd_addr_t1", {32'd0, addr_hist[0][(tg+1)%64]}, 64'h8000_0010);

    w0 = wr_cnt[0];
    txn(0, 1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678, 1'b0, 32'h0, 1'b0, tg, td);
    chk("wr_latency", 64'(td - tg), 64'd2);
    chk("wr_en_cycles", 64'(wr_cnt[0] - w0), 64'd1);
    chk("wr_en_at_t1", 64'(wr_cyc[0] - tg), 64'd1);
    txn(0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b1, 32'h1234_5678, 1'b0, tg, td);

    w0 = wr_cnt[0];
    txn(0, 1'b0, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, tg, td);
    chk("blk_latency", 64'(td - tg), 64'd2);
    chk("blk_no_wr_en", 64'(wr_cnt[0] - w0), 64'd0);
    txn(0, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 32'hA000_0002, 1'b0, tg, td);

    txn(1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, tg, td);
    chk("l3_latency", 64'(td - tg), 64'd5);
    for (int j = 1; j <= 3; j++) begin
      chk("l3_cs_held", {63'd0, cs_hist[1][(tg+j)%64]}, 64'd1);
      chk("l3_addr_held", {32'd0, addr_hist[1][(tg+j)%64]}, 64'h8000_0010);
    end

    // Abandon a latency-3 read in WAIT with an asynchronous reset.
    @(posedge clk); #1;
    r1_req[1] = 1'b1; r1_we[1] = 1'b0; r1_addr[1] = 32'h8000_0010;
    gnt_flag[1] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      got = gnt_flag[1];
    end
    chk("arst_gnt_seen", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    r1_req[1] = 1'b0;
    step();
    step();
    chk("arst_pre_cs", {63'd0, mem_chip_sel[1]}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_cs", {63'd0, mem_chip_sel[1]}, 64'd0);
    chk("arst_addr", {32'd0, mem_addr[1]}, 64'd0);
    chk("arst_done", {62'd0, r0_done[1], r1_done[1]}, 64'd0);
    chk("arst_rdata", {32'd0, r1_rdata[1]}, 64'd0);
    done_flag[1] = 1'b0;
    repeat (4) step();
    chk("arst_no_done", {63'd0, done_flag[1]}, 64'd0);
    rst_n = 1'b1;
    step();
    rr(1, 2, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: r0 (instruction fetch) and r1 (load/store unit).
- Round-robin arbitration, one transaction in flight, registered memory-side outputs.
- Read latency handled by a parameterised wait counter.
- Writes to instruction space (addr MSB = 0) are blocked and flagged.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte/word address width; MSB selects data space (1) or instruction space (0)
- MEM_LATENCY, 1, memory read latency in cycles from an address-valid cycle to rd_data valid; range 1..15

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- r0_req  in  1  fetch request; held with attributes until r0_gnt
- r0_we  in  1  fetch write enable (normally 0)
- r0_addr  in  ADDR_WIDTH  fetch address
- r0_wdata  in  DATA_WIDTH  fetch write data
- r0_gnt  out  1  one-cycle grant pulse
- r0_done  out  1  one-cycle completion pulse
- r0_rdata  out  DATA_WIDTH  read data, valid while r0_done=1
- r0_err  out  1  valid with r0_done; write to instruction space rejected
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_done, r1_rdata, r1_err: same as r0_*, for the load/store requester
- mem_chip_sel  out  1  memory select
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_wr_en  out  1  memory write enable
- mem_rd_data  in  DATA_WIDTH  memory read data

Behaviour:
- Clocking and reset: single clock, clk. Asynchronous active-low reset, rst_n.
- Reset values: all outputs 0; state IDLE; wait counter 0; last_gnt = 1, so r0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Only one req asserted: that requester wins.
  - Both asserted: winner is the requester not equal to last_gnt.
  - Winner's gnt is driven combinationally in the same cycle.
  - Command (we, addr, wdata, id) is latched and last_gnt updated; next state is ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle):
  - mem_chip_sel = 1 and mem_addr = latched addr, from registered outputs.
  - mem_wr_data = latched wdata.
  - mem_wr_en = latched we AND addr[ADDR_WIDTH-1].
  - Write: next state RESP.
  - Read: load counter with MEM_LATENCY-1, next state WAIT.
- WAIT:
  - mem_chip_sel and mem_addr stay held; mem_wr_en = 0.
  - Counter decrements each cycle.
  - When the counter is 0, mem_rd_data is captured into the rdata register and the next state is RESP.
- RESP (1 cycle):
  - The granted requester's done pulses for exactly one cycle; rdata/err are valid with it.
  - The other requester's done = 0.
  - mem_chip_sel = 0. Next state IDLE.
- Timing, with the grant in cycle T:
  - Memory access in T+1.
  - Read done in cycle T+2+MEM_LATENCY; write done in T+2.
  - Next grant no earlier than the cycle after done.
  - Back-to-back read throughput: one transaction per MEM_LATENCY+3 cycles.
- Instruction-space write (we=1, addr MSB=0): mem_wr_en stays 0, memory is untouched, done=1 with err=1, rdata = 0.
- Reads from either space are legal; err = 0.
- rdata register: retains its last value outside done; it is only guaranteed valid while done=1.
- Requester dropping req before gnt: no grant and no transaction; this is legal.
- Req after gnt: attributes are ignored until the next grant; req held high after gnt is treated as a new request in the next IDLE.
- Reset mid-transaction: the transaction is abandoned with no done pulse. Outputs return to reset values immediately (asynchronous). The memory may have seen a partial access; a write issued in the ISSUE cycle before reset is not rolled back.
- Every cycle: at most one gnt and at most one done.

Test Plan:
- Single read, MEM_LATENCY=1: r1 reads 0x8000_0010, memory returns 0xDEAD_BEEF.
  - r1_gnt in T; mem_chip_sel=1, mem_addr=0x8000_0010 in T+1.
  - r1_done=1, r1_rdata=0xDEAD_BEEF, r1_err=0 in T+3.
- Data write: r1 writes 0x1234_5678 to 0x8000_0004.
  - mem_wr_en=1 for exactly one cycle (T+1), r1_done in T+2.
  - A following read of 0x8000_0004 returns 0x1234_5678.
- Blocked write: r0 writes 0xFFFF_FFFF to 0x0000_0008.
  - mem_wr_en never asserted; r0_done=1 with r0_err=1 in T+2.
  - A subsequent read of 0x0000_0008 returns the original ROM word.
- Round-robin: r0 and r1 requesting continuously from reset.
  - Grant order r0, r1, r0, r1.
  - With MEM_LATENCY=1, grants are spaced 4 cycles apart.
- Latency sweep, MEM_LATENCY=3: read done appears exactly at T+5; mem_addr is held stable for T+1..T+3.
- Async reset: rst_n low during WAIT.
  - All outputs 0 immediately, no done pulse.
  - After release, a pending simultaneous request is granted to r0 first.
